// File: rtl/somador_sequencial.sv
// Chunk-serial adder/subtractor: CHUNK bits per cycle, LSB chunk first; result valid with done, N+1 edges after start.
// No backpressure: start is accepted only in IDLE/DONE and ignored while busy.
module somador_sequencial #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             overflow,
    output logic             busy,
    output logic             done
);

    localparam int N     = WIDTH / CHUNK;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

    if ((WIDTH % CHUNK) != 0) begin : g_bad_params
        $error("WIDTH must be a multiple of CHUNK");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               carry_q, carry_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   s_q, s_d;
    logic               cout_q, cout_d;
    logic               ovf_q, ovf_d;

    logic [CHUNK-1:0]   a_chunk;
    logic [CHUNK-1:0]   b_chunk;
    logic [CHUNK:0]     csum;

    // b is stored already inverted in subtract mode, so CALC is a plain add.
    assign a_chunk = a_q[idx_q*CHUNK +: CHUNK];
    assign b_chunk = b_q[idx_q*CHUNK +: CHUNK];
    assign csum    = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, carry_q};

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        s_d     = s_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = sub ? ~b : b;
                    carry_d = sub ? 1'b1 : cin;
                    idx_d   = '0;
                    state_d = CALC;
                end else begin
                    state_d = IDLE;
                end
            end
            CALC: begin
                s_d[idx_q*CHUNK +: CHUNK] = csum[CHUNK-1:0];
                carry_d = csum[CHUNK];
                idx_d   = idx_q + IDX_W'(1);
                if (idx_q == IDX_W'(N - 1)) begin
                    state_d = DONE;
                    cout_d  = csum[CHUNK];
                    // Same-sign operands producing an opposite-sign result.
                    ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                              (csum[CHUNK-1] != a_q[WIDTH-1]);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            s_q     <= s_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign s        = s_q;
    assign cout     = cout_q;
    assign overflow = ovf_q;
    assign busy     = (state_q == CALC);
    assign done     = (state_q == DONE);

endmodule

// File: tb/tb_somador_sequencial.sv
// Directed bench for somador_sequencial: 16-bit/4-bit-chunk and 8-bit/1-bit-chunk instances.
module tb_somador_sequencial;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start0, sub0, cin0;
    logic [15:0] a0, b0, s0;
    logic        cout0, ovf0, busy0, done0;
    logic        start1, sub1, cin1;
    logic [7:0]  a1, b1, s1;
    logic        cout1, ovf1, busy1, done1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    somador_sequencial #(.WIDTH(16), .CHUNK(4)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .sub(sub0), .a(a0), .b(b0),
        .cin(cin0), .s(s0), .cout(cout0), .overflow(ovf0), .busy(busy0), .done(done0)
    );

    somador_sequencial #(.WIDTH(8), .CHUNK(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .sub(sub1), .a(a1), .b(b1),
        .cin(cin1), .s(s1), .cout(cout1), .overflow(ovf1), .busy(busy1), .done(done1)
    );

    // Drives one operation on dut0 and returns edges from the start edge to done (-1 on timeout).
    task automatic run_op0(input logic [15:0] a, input logic [15:0] b,
                           input logic sb, input logic ci, output int lat);
        int cnt;
        a0 = a; b0 = b; sub0 = sb; cin0 = ci; start0 = 1'b1;
        @(posedge clk); #1;
        start0 = 1'b0;
        cnt = 0;
        while (!done0 && cnt < 20) begin
            @(posedge clk); #1;
            cnt++;
        end
        lat = done0 ? cnt : -1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({s0, cout0, ovf0, busy0, done0} !== 20'h0) begin
            errors++;
            $display("FAIL reset_dut0: got s=%h cout=%b ovf=%b busy=%b done=%b, want all 0",
                     s0, cout0, ovf0, busy0, done0);
        end
        checks++;
        if ({s1, cout1, ovf1, busy1, done1} !== 12'h0) begin
            errors++;
            $display("FAIL reset_dut1: got s=%h cout=%b ovf=%b busy=%b done=%b, want all 0",
                     s1, cout1, ovf1, busy1, done1);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_add();
        int lat;
        a0 = 16'h00FF; b0 = 16'h0001; sub0 = 1'b0; cin0 = 1'b0; start0 = 1'b1;
        @(posedge clk); #1;
        start0 = 1'b0;
        checks++;
        if (busy0 !== 1'b1) begin
            errors++;
            $display("FAIL busy_after_start: got %b, want 1", busy0);
        end
        lat = 0;
        while (!done0 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        checks++;
        if (lat !== 4 || busy0 !== 1'b0) begin
            errors++;
            $display("FAIL add_latency: got %0d edges busy=%b, want 4 edges busy=0", lat, busy0);
        end
        checks++;
        if ({s0, cout0, ovf0} !== {16'h0100, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL add_00ff: got s=%h c=%b v=%b, want 0100 0 0", s0, cout0, ovf0);
        end
        run_op0(16'hFFFF, 16'h0001, 1'b0, 1'b0, lat);
        checks++;
        if (lat !== 4 || {s0, cout0, ovf0} !== {16'h0000, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL add_ffff: got s=%h c=%b v=%b lat=%0d, want 0000 1 0 lat=4",
                     s0, cout0, ovf0, lat);
        end
        run_op0(16'hFFFF, 16'h0001, 1'b0, 1'b1, lat);
        checks++;
        if (lat !== 4 || {s0, cout0} !== {16'h0001, 1'b1}) begin
            errors++;
            $display("FAIL add_ffff_cin: got s=%h c=%b lat=%0d, want 0001 1 lat=4", s0, cout0, lat);
        end
        run_op0(16'h7FFF, 16'h0001, 1'b0, 1'b0, lat);
        checks++;
        if (lat !== 4 || {s0, cout0, ovf0} !== {16'h8000, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL add_ovf: got s=%h c=%b v=%b lat=%0d, want 8000 0 1 lat=4",
                     s0, cout0, ovf0, lat);
        end
    endtask

    task automatic test_sub();
        int lat;
        run_op0(16'h0005, 16'h0007, 1'b1, 1'b0, lat);
        checks++;
        if (lat !== 4 || {s0, cout0, ovf0} !== {16'hFFFE, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL sub_borrow: got s=%h c=%b v=%b lat=%0d, want fffe 0 0 lat=4",
                     s0, cout0, ovf0, lat);
        end
        run_op0(16'h8000, 16'h0001, 1'b1, 1'b0, lat);
        checks++;
        if (lat !== 4 || {s0, cout0, ovf0} !== {16'h7FFF, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL sub_ovf: got s=%h c=%b v=%b lat=%0d, want 7fff 1 1 lat=4",
                     s0, cout0, ovf0, lat);
        end
        // cin must have no effect in subtract mode.
        run_op0(16'h0009, 16'h0003, 1'b1, 1'b1, lat);
        checks++;
        if (lat !== 4 || {s0, cout0, ovf0} !== {16'h0006, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL sub_cin_ignored: got s=%h c=%b v=%b lat=%0d, want 0006 1 0 lat=4",
                     s0, cout0, ovf0, lat);
        end
    endtask

    task automatic test_busy_ignore();
        int lat;
        a0 = 16'h1234; b0 = 16'h1111; sub0 = 1'b0; cin0 = 1'b0; start0 = 1'b1;
        @(posedge clk); #1;
        start0 = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        a0 = 16'hFFFF; b0 = 16'hFFFF; sub0 = 1'b1; cin0 = 1'b1; start0 = 1'b1;
        @(posedge clk); #1;
        start0 = 1'b0;
        lat = 3;
        while (!done0 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        checks++;
        if (lat !== 4 || {s0, cout0, ovf0} !== {16'h2345, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL busy_ignore: got s=%h c=%b v=%b lat=%0d, want 2345 0 0 lat=4",
                     s0, cout0, ovf0, lat);
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({s0, cout0, ovf0, busy0, done0} !== {16'h2345, 4'b0000}) begin
            errors++;
            $display("FAIL idle_hold: got s=%h c=%b v=%b busy=%b done=%b, want 2345 0 0 0 0",
                     s0, cout0, ovf0, busy0, done0);
        end
    endtask

    task automatic test_back_to_back();
        int done_cyc[$];
        a0 = 16'h0001; b0 = 16'h0002; sub0 = 1'b0; cin0 = 1'b0; start0 = 1'b1;
        for (int cyc = 1; cyc <= 16; cyc++) begin
            @(posedge clk); #1;
            if (done0) done_cyc.push_back(cyc);
        end
        start0 = 1'b0;
        checks++;
        if (done_cyc.size() != 3) begin
            errors++;
            $display("FAIL b2b_count: got %0d done pulses, want 3", done_cyc.size());
        end else begin
            checks++;
            if (done_cyc[0] != 5 || done_cyc[1] != 10 || done_cyc[2] != 15) begin
                errors++;
                $display("FAIL b2b_spacing: got cycles %0d %0d %0d, want 5 10 15",
                         done_cyc[0], done_cyc[1], done_cyc[2]);
            end
        end
        checks++;
        if (s0 !== 16'h0003) begin
            errors++;
            $display("FAIL b2b_result: got s=%h, want 0003", s0);
        end
        repeat (8) @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid();
        int lat;
        bit saw_done;
        a0 = 16'hABCD; b0 = 16'h1111; sub0 = 1'b0; cin0 = 1'b0; start0 = 1'b1;
        @(posedge clk); #1;
        start0 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        checks++;
        if ({s0, cout0, ovf0, busy0, done0} !== 20'h0) begin
            errors++;
            $display("FAIL reset_mid_outputs: got s=%h c=%b v=%b busy=%b done=%b, want all 0",
                     s0, cout0, ovf0, busy0, done0);
        end
        saw_done = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (done0 || busy0) saw_done = 1;
        end
        checks++;
        if (saw_done) begin
            errors++;
            $display("FAIL reset_mid_abort: got done/busy activity after reset, want none");
        end
        run_op0(16'h0F0F, 16'h00F1, 1'b0, 1'b0, lat);
        checks++;
        if (lat !== 4 || {s0, cout0, ovf0} !== {16'h1000, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_mid_recover: got s=%h c=%b v=%b lat=%0d, want 1000 0 0 lat=4",
                     s0, cout0, ovf0, lat);
        end
    endtask

    task automatic test_width8();
        int lat;
        a1 = 8'hAA; b1 = 8'h55; sub1 = 1'b0; cin1 = 1'b1; start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        lat = 0;
        while (!done1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        checks++;
        if (lat !== 8) begin
            errors++;
            $display("FAIL w8_latency: got %0d edges, want 8", lat);
        end
        checks++;
        if ({s1, cout1, ovf1} !== {8'h00, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL w8_result: got s=%h c=%b v=%b, want 00 1 0", s1, cout1, ovf1);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        start0 = 1'b0; sub0 = 1'b0; cin0 = 1'b0; a0 = '0; b0 = '0;
        start1 = 1'b0; sub1 = 1'b0; cin1 = 1'b0; a1 = '0; b1 = '0;
        test_reset();
        test_add();
        test_sub();
        test_busy_ignore();
        test_back_to_back();
        test_reset_mid();
        test_width8();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
